// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the decode control unit.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package hazard_pkg;

    // Opcodes (bits [6:0] of the RV32I instruction)
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Destination info tracked for one pipeline stage
    typedef struct packed {
        logic       wr;     // stage will write rd
        logic       ld;     // stage is a load (result only available after MEM)
        logic [4:0] rd;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Per-opcode source/destination usage
    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } src_info_t;

    // True when a used, nonzero source register is produced by the given slot
    function automatic logic slot_match(input slot_t s, input logic [4:0] rs, input logic used);
        return used && (rs != 5'd0) && s.wr && (s.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage fields in, stall/flush controls and performance counters out.
// Latency: n/a (wires only).
// Backpressure: n/a; the controls themselves are the pipeline's backpressure.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       Opcode;
    logic [4:0]       Rs1;
    logic [4:0]       Rs2;
    logic [4:0]       Rd;
    logic             BranchTaken;
    logic             Stall;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             Flush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    // Pipeline side: supplies the ID fields, consumes the controls
    modport master (
        output Opcode, Rs1, Rs2, Rd, BranchTaken,
        input  Stall, PCWrite, IFIDWrite, Flush, StallCount, FlushCount
    );

    // Hazard unit side
    modport slave (
        input  Opcode, Rs1, Rs2, Rd, BranchTaken,
        output Stall, PCWrite, IFIDWrite, Flush, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_src_decode.sv
// Opcode classifier: which sources an instruction reads, whether it writes rd, whether it is a load.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module hazard_src_decode
    import hazard_pkg::*;
(
    input  logic [6:0] opcode,
    output src_info_t  info
);

    // Classify the opcode; anything unrecognised reads and writes nothing
    always_comb begin
        info = '0;
        case (opcode)
            OP_RTYPE: begin
                info.uses_rs1  = 1'b1;
                info.uses_rs2  = 1'b1;
                info.writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                info.uses_rs1 = 1'b1;
                info.uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                info.uses_rs1  = 1'b1;
                info.writes_rd = 1'b1;
                info.is_load   = 1'b1;
            end
            OP_ADDI: begin
                info.uses_rs1  = 1'b1;
                info.writes_rd = 1'b1;
            end
            default: info = '0;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller beside ID with EX/MEM destination shadows and saturating stall/flush counters.
// Latency: controls combinational in the same cycle; shadows and counters update on the rising edge.
// Backpressure: Stall deasserts PCWrite/IFIDWrite; Flush (BranchTaken) wins over Stall. HAZ_NO_FORWARDING_EN: stall on any EX/MEM writer.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    src_info_t        id_info;
    slot_t            id_slot;
    slot_t            ex_slot;
    logic             ex_hit;
    logic             raw_stall;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    hazard_src_decode u_src_decode (
        .opcode (hif.Opcode),
        .info   (id_info)
    );

    // Destination info the ID instruction carries into EX; x0 never counts as a write
    always_comb begin
        id_slot    = SLOT_BUBBLE;
        id_slot.rd = hif.Rd;
        if (hif.Rd != 5'd0) begin
            id_slot.wr = id_info.writes_rd;
            id_slot.ld = id_info.is_load;
        end
    end

    assign ex_hit = slot_match(ex_slot, hif.Rs1, id_info.uses_rs1)
                  | slot_match(ex_slot, hif.Rs2, id_info.uses_rs2);

`ifdef HAZ_NO_FORWARDING_EN
    // Without forwarding the MEM producer must also be waited out, so it is tracked and compared
    slot_t mem_slot;
    logic  mem_hit;

    assign mem_hit = slot_match(mem_slot, hif.Rs1, id_info.uses_rs1)
                   | slot_match(mem_slot, hif.Rs2, id_info.uses_rs2);

    // Any producer still in EX or MEM blocks the reader
    always_comb begin
        raw_stall = ex_hit | mem_hit;
    end

    // MEM shadow follows EX unless the pipe is flushed
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem_slot <= SLOT_BUBBLE;
        end else begin
            mem_slot <= ex_slot;
        end
    end
`else
    // With forwarding only a load in EX is too late to forward; a MEM producer is always forwarded
    always_comb begin
        raw_stall = ex_slot.ld & ex_hit;
    end
`endif

    // Reset forces the pipe to run; a taken branch kills the ID instruction so it must not stall
    always_comb begin
        flush = 1'b0;
        stall = 1'b0;
        if (!reset) begin
            flush = hif.BranchTaken;
            stall = raw_stall & ~hif.BranchTaken;
        end
    end

    assign hif.Stall      = stall;
    assign hif.Flush      = flush;
    assign hif.PCWrite    = ~stall;
    assign hif.IFIDWrite  = ~stall;
    assign hif.StallCount = stall_cnt;
    assign hif.FlushCount = flush_cnt;

    // EX shadow: bubble on flush or stall, otherwise take the ID instruction
    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_slot <= SLOT_BUBBLE;
        end else begin
            ex_slot <= id_slot;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: the driver queues hand-computed expectations per cycle,
// a monitor on the falling edge pops and compares them against the DUT outputs.
// Build with HAZ_NO_FORWARDING_EN to exercise the no-forwarding expectations.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int CW = 4;
`ifdef HAZ_NO_FORWARDING_EN
    localparam logic NF = 1'b1;
`else
    localparam logic NF = 1'b0;
`endif
    localparam logic [6:0] OP_NOP = 7'b0000000;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct {
        int            id;
        logic          stall;
        logic          flush;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        bit            chk;
    } exp_t;

    exp_t q[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   vec_id      = 0;
    logic [CW-1:0] m_sc = '0;
    logic [CW-1:0] m_fc = '0;

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CW)) hif ();

    hazard_unit #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    // Apply one ID-stage vector for the next cycle and queue what the DUT must show in it
    task automatic step(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic bt, input logic rst,
                        input logic est, input logic efl, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        hif.Opcode      = op;
        hif.Rs1         = rs1;
        hif.Rs2         = rs2;
        hif.Rd          = rd;
        hif.BranchTaken = bt;
        reset           = rst;
        e.id    = vec_id;
        e.stall = est;
        e.flush = efl;
        e.sc    = m_sc;
        e.fc    = m_fc;
        e.chk   = chk;
        q.push_back(e);
        vec_id++;
        // Counter values the DUT must hold after this cycle's edge
        if (rst) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (est && (m_sc != '1)) m_sc = m_sc + 1'b1;
            if (efl && (m_fc != '1)) m_fc = m_fc + 1'b1;
        end
    endtask

    task automatic cmp(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents its controls; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                cmp("Stall",     e.id, {15'd0, hif.Stall},     {15'd0, e.stall});
                cmp("Flush",     e.id, {15'd0, hif.Flush},     {15'd0, e.flush});
                cmp("PCWrite",   e.id, {15'd0, hif.PCWrite},   {15'd0, ~e.stall});
                cmp("IFIDWrite", e.id, {15'd0, hif.IFIDWrite}, {15'd0, ~e.stall});
                if (e.chk) begin
                    cmp("StallCount", e.id, {12'd0, hif.StallCount}, {12'd0, e.sc});
                    cmp("FlushCount", e.id, {12'd0, hif.FlushCount}, {12'd0, e.fc});
                end
            end
        end
    end

    initial begin
        hif.Opcode      = OP_NOP;
        hif.Rs1         = '0;
        hif.Rs2         = '0;
        hif.Rd          = '0;
        hif.BranchTaken = 1'b0;

        // Reset: branch pulse must not flush while reset is high
        step(OP_NOP,    0, 0, 0, 1, 1, 0, 0, 0);
        step(OP_NOP,    0, 0, 0, 0, 1, 0, 0, 1);

        // ld x5,0(x1) ; add x6,x5,x2 -> one stall (two without forwarding)
        step(OP_LOAD,   1, 0, 5, 0, 0, 0, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, 1, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, NF, 0, 1);
`ifdef HAZ_NO_FORWARDING_EN
        step(OP_RTYPE,  5, 2, 6, 0, 0, 0, 0, 1);
`endif
        step(OP_NOP,    0, 0, 0, 0, 0, 0, 0, 1);

        // ld x0 ; add x6,x0,x2 -> x0 never hazards
        step(OP_LOAD,   1, 0, 0, 0, 0, 0, 0, 1);
        step(OP_RTYPE,  0, 2, 6, 0, 0, 0, 0, 1);

        // ld x7 ; sw x7,0(x2) -> hazard through rs2
        step(OP_LOAD,   2, 0, 7, 0, 0, 0, 0, 1);
        step(OP_STORE,  2, 7, 7, 0, 0, 1, 0, 1);
        step(OP_STORE,  2, 7, 7, 0, 0, NF, 0, 1);
`ifdef HAZ_NO_FORWARDING_EN
        step(OP_STORE,  2, 7, 7, 0, 0, 0, 0, 1);
`endif

        // ld x9 ; jal with rs fields = 9 -> no sources, no stall
        step(OP_LOAD,   1, 0, 9, 0, 0, 0, 0, 1);
        step(OP_JAL,    9, 9, 1, 0, 0, 0, 0, 1);

        // addi x5,x1,4 ; add x6,x5,x2 -> forwarded, or two stalls without forwarding
        step(OP_ADDI,   1, 0, 5, 0, 0, 0, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, NF, 0, 1);
`ifdef HAZ_NO_FORWARDING_EN
        step(OP_RTYPE,  5, 2, 6, 0, 0, 1, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, 0, 0, 1);
`endif
        step(OP_NOP,    0, 0, 0, 0, 0, 0, 0, 1);

        // ld x5 ; add with BranchTaken -> flush wins, next cycle slots are bubbles
        step(OP_LOAD,   1, 0, 5, 0, 0, 0, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 1, 0, 0, 1, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, 0, 0, 1);
        step(OP_BRANCH, 3, 4, 0, 1, 0, 0, 1, 1);
        step(OP_NOP,    0, 0, 0, 0, 0, 0, 0, 1);

        // 20 load-use stalls: StallCount saturates at 15
        for (int i = 0; i < 20; i++) begin
            step(OP_LOAD,  1, 0, 5, 0, 0, 0, 0, 1);
            step(OP_RTYPE, 5, 2, 6, 0, 0, 1, 0, 1);
            step(OP_RTYPE, 5, 2, 6, 0, 0, NF, 0, 1);
`ifdef HAZ_NO_FORWARDING_EN
            step(OP_RTYPE, 5, 2, 6, 0, 0, 0, 0, 1);
`endif
        end
        step(OP_NOP,    0, 0, 0, 0, 0, 0, 0, 1);

        // Reset during a stall: released immediately, no stall for the pending add afterwards
        step(OP_LOAD,   1, 0, 5, 0, 0, 0, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, 1, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 1, 0, 0, 1);
        step(OP_RTYPE,  5, 2, 6, 0, 0, 0, 0, 1);
        step(OP_NOP,    0, 0, 0, 0, 0, 0, 0, 1);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
